// File: rtl/step_pulse_gen.sv
// Single-step front end: synchronizes and debounces a push-button. Each accepted
// press yields one strobe, one stretched step clock and one counter increment.
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_WIDTH     = 16,
    parameter int unsigned STEP_CNT_W      = 16
) (
    input  logic                  clk_100M,
    input  logic                  rst,
    input  logic                  btn_in,
    output logic                  step_clk,
    output logic                  step_pulse,
    output logic                  btn_level,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned WID_W = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WID_W-1:0] WID_LOAD = WID_W'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic                    s1_q, s2_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WID_W-1:0]        wid_q, wid_d;
    logic                    step_clk_q, step_clk_d;
    logic                    pulse_q, pulse_d;
    logic                    level_q, level_d;
    logic [STEP_CNT_W-1:0]   count_q, count_d;

    // NOTE: every variable gets a default first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        level_d    = level_q;
        count_d    = count_q;
        wid_d      = wid_q;
        step_clk_d = step_clk_q;

        // Step clock stretcher: falls on the edge where the width counter hits zero.
        if (wid_q != '0) begin
            wid_d      = wid_q - 1'b1;
            step_clk_d = (wid_q != WID_W'(1));
        end

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = HELD;
                    cnt_d      = '0;
                    pulse_d    = 1'b1;
                    level_d    = 1'b1;
                    count_d    = count_q + 1'b1;
                    wid_d      = WID_LOAD;
                    step_clk_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                level_d = 1'b1;
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A short return to high is release bounce: back to HELD, no new step.
                if (s2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_100M or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            cnt_q      <= '0;
            wid_q      <= '0;
            step_clk_q <= 1'b0;
            pulse_q    <= 1'b0;
            level_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= btn_in;
            s2_q       <= s1_q;
            cnt_q      <= cnt_d;
            wid_q      <= wid_d;
            step_clk_q <= step_clk_d;
            pulse_q    <= pulse_d;
            level_q    <= level_d;
            count_q    <= count_d;
        end
    end

    assign step_clk   = step_clk_q;
    assign step_pulse = pulse_q;
    assign btn_level  = level_q;
    assign step_count = count_q;

endmodule
